// File: rtl/pattern_pkg.sv
// ============================================================================
// Package : pattern_pkg
// Shared constants and FSM state type for the pattern buffer loader.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package pattern_pkg;

    localparam int BUFSIZE = 27;
    localparam int CNT_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pattern_serializer.sv
// ============================================================================
// Module : pattern_serializer
// 8-bit load/shift register presenting the current bit MSB-first, with bit index.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pattern_serializer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] data,
    output logic       sin,
    output logic       last_bit
);

    logic [7:0] sreg;
    logic [2:0] bit_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg    <= '0;
            bit_idx <= '0;
        end else if (load) begin
            sreg    <= data;
            bit_idx <= 3'd7;
        end else if (shift) begin
            sreg    <= {sreg[6:0], 1'b0};
            bit_idx <= bit_idx - 3'd1;
        end
    end

    // sin comes straight from a flop, so the buffer sees a registered serial bit.
    assign sin      = sreg[7];
    assign last_bit = (bit_idx == 3'd0);

endmodule

`default_nettype wire

// File: rtl/pattern_loader.sv
// ============================================================================
// Module : pattern_loader
// Streams BUFSIZE host bytes MSB-first into the pattern buffer and pulses done.
// Optional readback of the old buffer contents: define PATTERN_READBACK_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pattern_loader
    import pattern_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ssel,
    output logic             sin,
    input  logic             sout,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] byte_cnt,
    output logic [7:0]       rb_data,
    output logic             rb_valid
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BUFSIZE - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFSIZE);

    state_t           state;
    state_t           state_nxt;
    logic             ssel_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             load;
    logic             shift;
    logic             last_bit;

    pattern_serializer u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift    (shift),
        .data     (in_data),
        .sin      (sin),
        .last_bit (last_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ssel     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            byte_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ssel     <= ssel_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            byte_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ssel_nxt  = 1'b0;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        cnt_nxt   = byte_cnt;
        in_ready  = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_WAIT;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end
            end
            ST_WAIT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    ssel_nxt  = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift = 1'b1;
                if (!last_bit) begin
                    ssel_nxt = 1'b1;
                end else begin
                    if (byte_cnt != FULL_CNT) begin
                        cnt_nxt = byte_cnt + CNT_W'(1);
                    end
                    if (byte_cnt == LAST_CNT) begin
                        state_nxt = ST_DONE;
                    end else begin
                        // Accepting on the last bit keeps the stream gapless: 8 clk per byte.
                        in_ready = 1'b1;
                        if (in_valid) begin
                            load     = 1'b1;
                            shift    = 1'b0;
                            ssel_nxt = 1'b1;
                        end else begin
                            state_nxt = ST_WAIT;
                        end
                    end
                end
            end
            ST_DONE: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Abort overrides everything, including a coincident start or accept.
        if (abort) begin
            state_nxt = ST_IDLE;
            ssel_nxt  = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b0;
            cnt_nxt   = byte_cnt;
            load      = 1'b0;
            shift     = 1'b0;
        end
    end

`ifdef PATTERN_READBACK_EN
    logic [6:0] rb_shift;
    logic [2:0] rb_bits;

    // sout is the pre-shift MSB, so bytes emerge oldest-first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rb_shift <= '0;
            rb_bits  <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (abort) begin
                rb_shift <= '0;
                rb_bits  <= '0;
            end else if (ssel) begin
                rb_shift <= {rb_shift[5:0], sout};
                rb_bits  <= rb_bits + 3'd1;
                if (rb_bits == 3'd7) begin
                    rb_data  <= {rb_shift, sout};
                    rb_valid <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_sout;
    assign unused_sout = sout;
    assign rb_data     = '0;
    assign rb_valid    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pattern_loader.sv
// Bench for pattern_loader: models the pattern buffer, scoreboards loads and readback.
`timescale 1ns/1ps
`default_nettype none

module tb_pattern_loader;
    import pattern_pkg::*;

    localparam int NBITS = 8 * BUFSIZE;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [7:0]       in_data = 8'h00;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             ssel;
    logic             sin;
    logic             sout;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] byte_cnt;
    logic [7:0]       rb_data;
    logic             rb_valid;

    always #5 clk = ~clk;

    pattern_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ssel     (ssel),
        .sin      (sin),
        .sout     (sout),
        .busy     (busy),
        .done     (done),
        .byte_cnt (byte_cnt),
        .rb_data  (rb_data),
        .rb_valid (rb_valid)
    );

    // Behavioural pattern buffer: 27 bytes, shifts left on ssel, MSB drives sout.
    logic [NBITS-1:0] pbuf = '0;
    logic             preload_req = 1'b0;
    logic [NBITS-1:0] preload_val = '0;
    always @(posedge clk) begin
        if (preload_req)  pbuf <= preload_val;
        else if (ssel)    pbuf <= {pbuf[NBITS-2:0], sin};
    end
    assign sout = pbuf[NBITS-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int ssel_cnt = 0;

    typedef struct packed {
        int               done_cyc;
        int               ssel_total;
        logic [NBITS-1:0] pat;
    } load_exp_t;

    load_exp_t  load_q[$];
    logic [7:0] rb_q[$];

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents done or a readback strobe.
    always @(negedge clk) begin
        if (!rst) begin
            if (ssel) ssel_cnt++;
            if (done) begin
                if (load_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    load_exp_t e;
                    e = load_q.pop_front();
                    check("done_cycle", 64'(cyc), 64'(e.done_cyc));
                    check("ssel_cycles", 64'(ssel_cnt), 64'(e.ssel_total));
                    check("done_byte_cnt", 64'(byte_cnt), 64'(BUFSIZE));
                    check("done_busy", 64'(busy), 64'd0);
                    for (int k = 0; k < BUFSIZE; k++)
                        check($sformatf("pattern[%0d]", k), 64'(pbuf[8*k +: 8]), 64'(e.pat[8*k +: 8]));
                end
            end
            if (rb_valid) begin
                if (rb_q.size() == 0) check("unexpected_rb_valid", 64'd1, 64'd0);
                else                  check("rb_data", 64'(rb_data), 64'(rb_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NBITS-1:0] rand_vec();
        logic [NBITS-1:0] v;
        for (int i = 0; i < BUFSIZE; i++) v[8*i +: 8] = 8'($urandom);
        return v;
    endfunction

    task automatic do_preload(input logic [NBITS-1:0] v);
        preload_val = v;
        preload_req = 1'b1;
        tick();
        preload_req = 1'b0;
    endtask

    // Old buffer bytes leave oldest-first: pattern[26], [25], ...
    task automatic push_rb(input logic [NBITS-1:0] old, input int n);
`ifdef PATTERN_READBACK_EN
        for (int j = 0; j < n; j++) rb_q.push_back(old[8*(BUFSIZE-1-j) +: 8]);
`else
        if (n < 0) $display("bad count %0d for %0h", n, old[0]);
`endif
    endtask

    task automatic send_byte(input logic [7:0] b, output int acc);
        int n;
        n = 0;
        acc = -1;
        in_data = b;
        in_valid = 1'b1;
        while (acc < 0 && n < 40) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                acc = cyc;
            end else begin
                @(posedge clk);
                #1;
            end
            n++;
        end
        in_valid = 1'b0;
        if (acc < 0) check("accept_timeout", 64'd1, 64'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Full load: d holds byte i in d[8*i+:8]. Expected done time is derived from
    // the first accept plus 1 + 8*BUFSIZE, extended by every stall cycle injected.
    task automatic run_load(input logic [NBITS-1:0] d, input logic [NBITS-1:0] old,
                            input int max_gap, input int gap_idx, input int gap_len,
                            input bit poke_start);
        load_exp_t e;
        int acc, first, stall, g, base, n;
        logic [CNT_W-1:0] cnt_before;
        do_preload(old);
        push_rb(old, BUFSIZE);
        base = ssel_cnt;
        pulse_start();
        check("start_busy", 64'(busy), 64'd1);
        check("start_byte_cnt", 64'(byte_cnt), 64'd0);
        stall = 0;
        first = 0;
        for (int i = 0; i < BUFSIZE; i++) begin
            g = 0;
            if (i == gap_idx) g = gap_len;
            else if (i > 0 && max_gap > 0 && $urandom_range(0, 3) == 0) g = $urandom_range(1, max_gap);
            if (g > 0) begin
                repeat (7 + g) @(posedge clk);
                #1;
                stall += g;
            end
            send_byte(d[8*i +: 8], acc);
            if (i == 0) first = acc;
            if (poke_start && i == 5) begin
                cnt_before = byte_cnt;
                pulse_start();
                check("start_while_busy_cnt", 64'(byte_cnt), 64'(cnt_before));
                check("start_while_busy_busy", 64'(busy), 64'd1);
            end
        end
        e.done_cyc = first + 1 + 8 * BUFSIZE + stall;
        e.ssel_total = base + 8 * BUFSIZE;
        for (int i = 0; i < BUFSIZE; i++) e.pat[8*(BUFSIZE-1-i) +: 8] = d[8*i +: 8];
        load_q.push_back(e);
        n = 0;
        while (load_q.size() > 0 && n < 40) begin
            tick();
            n++;
        end
        if (load_q.size() > 0) begin
            check("done_timeout", 64'd1, 64'd0);
            void'(load_q.pop_front());
        end
        in_valid = 1'b1;
        check("idle_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NBITS-1:0] d, old;
        int acc, base;

        // Reset values
        repeat (3) tick();
        check("rst_ssel", 64'(ssel), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_byte_cnt", 64'(byte_cnt), 64'd0);
        rst = 1'b0;
        tick();

        // Asynchronous reset in the middle of a shifted byte (bit index 4)
        old = rand_vec();
        do_preload(old);
        push_rb(old, 1);
        pulse_start();
        send_byte(8'hC3, acc);
        send_byte(8'h5A, acc);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_ssel", 64'(ssel), 64'd0);
        check("arst_sin", 64'(sin), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_byte_cnt", 64'(byte_cnt), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd0);
        check("arst_rb_data", 64'(rb_data), 64'd0);
        check("arst_rb_valid", 64'(rb_valid), 64'd0);
        tick();
        rst = 1'b0;
        base = ssel_cnt;
        repeat (20) tick();
        check("post_rst_no_ssel", 64'(ssel_cnt), 64'(base));
        check("post_rst_busy", 64'(busy), 64'd0);

        // Directed 0x00..0x1A back-to-back, then with a 5-cycle stall after byte 3
        for (int i = 0; i < BUFSIZE; i++) d[8*i +: 8] = 8'(i);
        run_load(d, rand_vec(), 0, -1, 0, 1'b0);
        run_load(d, rand_vec(), 0, 3, 5, 1'b0);

        // Abort after 10 bytes + 3 bits
        old = rand_vec();
        do_preload(old);
        push_rb(old, 10);
        pulse_start();
        for (int i = 0; i < 11; i++) send_byte(8'($urandom), acc);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_ssel", 64'(ssel), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        check("abort_byte_cnt", 64'(byte_cnt), 64'd10);
        repeat (20) tick();
        check("abort_cnt_hold", 64'(byte_cnt), 64'd10);
        run_load(rand_vec(), rand_vec(), 0, -1, 0, 1'b0);

        // start and abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        in_valid = 1'b1;
        check("start_abort_busy", 64'(busy), 64'd0);
        check("start_abort_in_ready", 64'(in_ready), 64'd0);
        repeat (3) tick();
        check("start_abort_idle", 64'(in_ready), 64'd0);
        in_valid = 1'b0;

        // start pulsed while busy is ignored
        run_load(rand_vec(), rand_vec(), 0, -1, 0, 1'b1);

        // Readback ordering with known head bytes, then randomized stalls
        old = rand_vec();
        old[8*26 +: 8] = 8'hA5;
        old[8*25 +: 8] = 8'h3C;
        run_load(rand_vec(), old, 0, -1, 0, 1'b0);
        for (int r = 0; r < 3; r++) run_load(rand_vec(), rand_vec(), 6, -1, 0, 1'b0);

        repeat (5) tick();
        check("load_queue_empty", 64'(load_q.size()), 64'd0);
        check("rb_queue_empty", 64'(rb_q.size()), 64'd0);
`ifndef PATTERN_READBACK_EN
        check("rb_data_tied", 64'(rb_data), 64'd0);
        check("rb_valid_tied", 64'(rb_valid), 64'd0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
